// File: rtl/hub75_bcm_scan.sv
// HUB75 scan engine: double-buffered column shift with binary-coded-modulation
// output enable, N parallel chains, configurable geometry and shift-clock divider.
module hub75_bcm_scan #(
    parameter int NUM_CHAINS = 2,
    parameter int ADDR_BITS  = 5,
    parameter int PLANES     = 8,
    parameter int COL_BITS   = 10,
    parameter int MEM_LAT    = 2,
    parameter int CLK_DIV    = 3
) (
    input  logic                                         PCLK,
    input  logic                                         PRESETN,
    input  logic                                         enable,
    input  logic [COL_BITS-1:0]                          pixels_per_row,
    input  logic [15:0]                                  bcm_unit,
    input  logic [7:0]                                   blank_cycles,
    output logic                                         rd_en,
    output logic [$clog2(PLANES)+ADDR_BITS+COL_BITS-1:0] rd_addr,
    input  logic [6*NUM_CHAINS-1:0]                      rd_data,
    output logic [6*NUM_CHAINS-1:0]                      rgb,
    output logic                                         led_clk,
    output logic                                         latch,
    output logic                                         oe_n,
    output logic [ADDR_BITS-1:0]                         abcde,
    output logic                                         frame_sync,
    output logic                                         busy
);

    localparam int PB  = $clog2(PLANES);
    localparam int OEW = 16 + PLANES - 1;
    localparam int SW  = $clog2(2 * CLK_DIV);

    typedef enum logic [2:0] {
        IDLE, SHIFT, WAIT_OE, BLANK_PRE, LATCH, BLANK_POST, WAIT_OE_DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [COL_BITS-1:0]  ppr_sh;
    logic [15:0]          bcm_sh;
    logic [7:0]           blank_sh;
    logic [PB-1:0]        plane;
    logic [ADDR_BITS-1:0] row;
    logic [COL_BITS-1:0]  col;
    logic [SW-1:0]        slot;
    logic [7:0]           phase;
    logic [OEW-1:0]       oe_cnt;

    logic slot_end, last_col, shift_done, oe_last, enter_pre;
    logic latch_done, post_done, plane_wrap, row_wrap, frame_wrap;
    logic start, keep_running;
    state_t pre_state, run_state;

    always_comb begin
        slot_end     = (slot == SW'(2 * CLK_DIV - 1));
        last_col     = (col == ppr_sh - COL_BITS'(1));
        shift_done   = (state == SHIFT) && slot_end && last_col;
        // Leaving at count 1 makes blanking start in the cycle oe_n rises.
        oe_last      = (oe_cnt <= OEW'(1));
        enter_pre    = ((state == WAIT_OE) || shift_done) && oe_last;
        latch_done   = (state == LATCH) && (phase == 8'd1);
        post_done    = (latch_done && (blank_sh == 8'd0)) ||
                       ((state == BLANK_POST) && (phase == blank_sh - 8'd1));
        plane_wrap   = (plane == PB'(PLANES - 1));
        row_wrap     = plane_wrap && (row == '1);
        frame_wrap   = post_done && row_wrap;
        start        = (state == IDLE) && enable && (pixels_per_row != '0);
        keep_running = enable && (!row_wrap || (pixels_per_row != '0));
        pre_state    = (blank_sh == 8'd0) ? LATCH : BLANK_PRE;
        run_state    = keep_running ? SHIFT : WAIT_OE_DRAIN;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:          if (start) state_nxt = SHIFT;
            SHIFT:         if (shift_done) state_nxt = oe_last ? pre_state : WAIT_OE;
            WAIT_OE:       if (oe_last) state_nxt = pre_state;
            BLANK_PRE:     if (phase == blank_sh - 8'd1) state_nxt = LATCH;
            LATCH:         if (latch_done) state_nxt = (blank_sh == 8'd0) ? run_state : BLANK_POST;
            BLANK_POST:    if (post_done) state_nxt = run_state;
            WAIT_OE_DRAIN: if (oe_last) state_nxt = IDLE;
            default:       state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_en   = (state == SHIFT) && (slot == '0);
        rd_addr = {plane, row, col};
        led_clk = (state == SHIFT) && (slot >= SW'(CLK_DIV));
        latch   = (state == LATCH);
        oe_n    = (oe_cnt == '0);
        busy    = (state != IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            ppr_sh     <= '0;
            bcm_sh     <= '0;
            blank_sh   <= '0;
            plane      <= '0;
            row        <= '0;
            col        <= '0;
            slot       <= '0;
            phase      <= '0;
            oe_cnt     <= '0;
            rgb        <= '0;
            abcde      <= '0;
            frame_sync <= 1'b0;
        end else begin
            phase      <= (state_nxt != state) ? 8'd0 : phase + 8'd1;
            frame_sync <= frame_wrap;

            if (start || frame_wrap) begin
                ppr_sh   <= pixels_per_row;
                bcm_sh   <= bcm_unit;
                blank_sh <= blank_cycles;
            end

            if (start) begin
                plane <= '0;
                row   <= '0;
                col   <= '0;
                slot  <= '0;
            end else if (state == SHIFT) begin
                slot <= slot_end ? '0 : slot + SW'(1);
                if (slot_end && !last_col) col <= col + COL_BITS'(1);
            end

            if ((state == SHIFT) && (slot == SW'(MEM_LAT))) rgb <= rd_data;
            if (enter_pre) abcde <= row;

            if (post_done) begin
                oe_cnt <= OEW'(bcm_sh) << plane;
                col    <= '0;
                slot   <= '0;
                if (plane_wrap) begin
                    plane <= '0;
                    row   <= row + ADDR_BITS'(1);
                end else begin
                    plane <= plane + PB'(1);
                end
            end else if (oe_cnt != '0) begin
                oe_cnt <= oe_cnt - OEW'(1);
            end
        end
    end

endmodule
